// File: rtl/mux4_pkg.sv
// Shared definitions for the 4-channel round-robin mux feeder.
//  - sel encodings for each channel (the mux selects ch0 on sel=2'b11)
//  - ch2sel(): channel index -> mux sel encoding
//  - feeder_st_t: feeder FSM states
package mux4_pkg;

  localparam logic [1:0] SEL_CH0 = 2'b11;
  localparam logic [1:0] SEL_CH1 = 2'b10;
  localparam logic [1:0] SEL_CH2 = 2'b01;
  localparam logic [1:0] SEL_CH3 = 2'b00;

  // The downstream mux decodes sel inverted relative to channel order.
  function automatic logic [1:0] ch2sel(input logic [1:0] idx);
    return ~idx;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } feeder_st_t;

endpackage

// File: rtl/mux4_rr_feeder_if.sv
// Bus between the upstream channels / downstream mux and the feeder.
//  in_valid/in_data/in_ready : per-channel upstream handshake
//  d0..d3, sel               : mux data inputs and registered grant
//  out_valid/out_ready       : downstream handshake for mux_out
//  dbg_state/dbg_rr_ptr      : feeder FSM state and round-robin pointer
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both 1; a valid side holds its payload stable
// until that edge, and ready never depends on the same cycle's valid.
interface mux4_rr_feeder_if
  import mux4_pkg::*;
#(
  parameter int DW  = 2,
  parameter int NCH = 4
);
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic [DW-1:0]     d0;
  logic [DW-1:0]     d1;
  logic [DW-1:0]     d2;
  logic [DW-1:0]     d3;
  logic [1:0]        sel;
  logic              out_valid;
  logic              out_ready;
  feeder_st_t        dbg_state;
  logic [1:0]        dbg_rr_ptr;

  // master: upstream sources plus downstream consumer (the environment)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, d0, d1, d2, d3, sel, out_valid, dbg_state, dbg_rr_ptr
  );

  // slave: the feeder itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, d0, d1, d2, d3, sel, out_valid, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick.
//  req     : request vector, bit i = channel i
//  ptr     : highest-priority channel; scan order ptr, ptr+1, ... mod 4
//  gnt_vld : some request was found
//  gnt_idx : index of the first request in scan order (ptr when none)
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_vld,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = ptr;
    for (int k = 0; k < 4; k++) begin
      // 2-bit add wraps naturally: 3 -> 0
      idx = ptr + 2'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_feeder.sv
// Round-robin feeder for the 4:1 2-bit output mux.
// Buffers one word per channel, arbitrates among full buffers round-robin
// and presents the winner to the mux via sel (mux encoding, ~ch_idx).
//  clk, rst : rising-edge clock, synchronous active-high reset
//  bus      : mux4_rr_feeder_if.slave (channel inputs, d0..d3, sel,
//             out_valid/out_ready, debug state and rr pointer)
module mux4_rr_feeder
  import mux4_pkg::*;
#(
  parameter int DW  = 2,
  parameter int NCH = 4
)(
  input logic             clk,
  input logic             rst,
  mux4_rr_feeder_if.slave bus
);

  logic [NCH-1:0] full;
  logic [DW-1:0]  data_q [NCH];
  logic [1:0]     sel_q, sel_n;
  logic [1:0]     rr_ptr, rr_ptr_n;
  feeder_st_t     state, state_n;

  logic [1:0]     g_idx;
  logic           consume;
  logic           upd;
  logic [NCH-1:0] consume_mask;
  logic [NCH-1:0] cand;
  logic           gnt_vld;
  logic [1:0]     gnt_idx;

  // The current grant is recovered from sel since sel = ~ch_idx.
  assign g_idx        = ~sel_q;
  assign consume      = (state == GRANT) && bus.out_ready;
  assign consume_mask = consume ? (NCH'(1) << g_idx) : '0;
  // A channel being consumed this edge must not win again at the same edge.
  // Data loaded at this edge is not yet in full, so it cannot compete either.
  assign cand         = full & ~consume_mask;
  // Re-arbitrate only when nothing is stalled downstream.
  assign upd          = (state == IDLE) || bus.out_ready;

  rr_arb4 u_arb (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    rr_ptr_n = rr_ptr;
    if (upd) begin
      if (gnt_vld) begin
        state_n  = GRANT;
        sel_n    = ch2sel(gnt_idx);
        rr_ptr_n = gnt_idx + 2'd1;
      end else begin
        state_n  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= SEL_CH0;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_n;
      sel_q  <= sel_n;
      rr_ptr <= rr_ptr_n;
    end
  end

  // Per-channel one-word buffers. Load and consume of the same channel can
  // never coincide because in_ready is low while the buffer is full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        full[i]   <= 1'b0;
        data_q[i] <= '0;
      end else if (bus.in_valid[i] && !full[i]) begin
        full[i]   <= 1'b1;
        data_q[i] <= bus.in_data[i*DW +: DW];
      end else if (consume_mask[i]) begin
        full[i]   <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.d0         = data_q[0];
  assign bus.d1         = data_q[1];
  assign bus.d2         = data_q[2];
  assign bus.d3         = data_q[3];
  assign bus.sel        = sel_q;
  assign bus.out_valid  = (state == GRANT);
  assign bus.dbg_state  = state;
  assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Directed testbench for mux4_rr_feeder. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point.
module tb_mux4_rr_feeder;
  import mux4_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mux4_rr_feeder_if #(.DW(2), .NCH(4)) bus ();

  mux4_rr_feeder #(.DW(2), .NCH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of the downstream 4:1 mux (sel=11 picks d0 ... sel=00 picks d3).
  function automatic logic [1:0] mux_out(input logic [1:0] s);
    case (s)
      2'b11:   return bus.d0;
      2'b10:   return bus.d1;
      2'b01:   return bus.d2;
      default: return bus.d3;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [1:0] exp_sel5 [7] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
  logic       exp_ov5  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] exp_dat5 [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

  initial begin
    // 1: reset held two edges while every channel offers data
    rst = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    bus.in_valid = 4'h0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sel",       32'(bus.sel),       32'(2'b11));
    check("rst_in_ready",  32'(bus.in_ready),  32'hF);
    check("rst_d",         32'({bus.d3, bus.d2, bus.d1, bus.d0}), 32'h0);
    check("rst_rr_ptr",    32'(bus.dbg_rr_ptr), 32'd0);

    // 2: single channel ch2 = 2'b10
    bus.in_valid  = 4'b0100;
    bus.in_data   = 8'b00_10_00_00;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 4'h0;
    check("t2_load_ready", 32'(bus.in_ready),  32'b1011);
    check("t2_load_ov",    32'(bus.out_valid), 32'd0);
    step();
    check("t2_ov",    32'(bus.out_valid),   32'd1);
    check("t2_sel",   32'(bus.sel),         32'(2'b01));
    check("t2_d2",    32'(bus.d2),          32'(2'b10));
    check("t2_mux",   32'(mux_out(bus.sel)), 32'(2'b10));
    check("t2_state", 32'(bus.dbg_state),   32'(GRANT));
    step();
    check("t2_ov_end",    32'(bus.out_valid),  32'd0);
    check("t2_ready_end", 32'(bus.in_ready),   32'hF);
    check("t2_ptr",       32'(bus.dbg_rr_ptr), 32'd3);

    // 3: all four loaded at once, drained in order ch0..ch3
    reset_pulse();
    bus.in_valid = 4'hF;
    bus.in_data  = 8'b11_10_01_00;
    step();
    bus.in_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_ov",  32'(bus.out_valid), 32'd1);
      check("t3_sel", 32'(bus.sel), 32'(ch2sel(2'(k))));
      check("t3_mux", 32'(mux_out(bus.sel)), 32'(k));
    end
    step();
    check("t3_ov_end", 32'(bus.out_valid), 32'd0);
    check("t3_ptr",    32'(bus.dbg_rr_ptr), 32'd0);

    // 4: backpressure on ch1 grant, ch3 waiting
    bus.in_valid  = 4'b1010;
    bus.in_data   = 8'b10_00_01_00;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_hold_ov",    32'(bus.out_valid),   32'd1);
      check("t4_hold_sel",   32'(bus.sel),         32'(2'b10));
      check("t4_hold_d1",    32'(bus.d1),          32'(2'b01));
      check("t4_hold_ready", 32'(bus.in_ready[1]), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check("t4_next_ov",    32'(bus.out_valid),   32'd1);
    check("t4_next_sel",   32'(bus.sel),         32'(2'b00));
    check("t4_next_mux",   32'(mux_out(bus.sel)), 32'(2'b10));
    check("t4_next_ready", 32'(bus.in_ready[1]), 32'd1);
    step();
    check("t4_ov_end", 32'(bus.out_valid), 32'd0);

    // 5: ch0 and ch3 always offering; grants alternate with an idle slot
    //    because a channel cannot be refilled on the edge it is consumed
    bus.in_valid = 4'b1001;
    bus.in_data  = 8'b10_00_00_01;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t5_ov", 32'(bus.out_valid), 32'(exp_ov5[k]));
      if (exp_ov5[k]) begin
        check("t5_sel", 32'(bus.sel), 32'(exp_sel5[k]));
        check("t5_mux", 32'(mux_out(bus.sel)), 32'(exp_dat5[k]));
      end
      if (k == 1) check("t5_ptr_after_ch0", 32'(bus.dbg_rr_ptr), 32'd1);
      if (k == 2) check("t5_ptr_wrap",      32'(bus.dbg_rr_ptr), 32'd0);
    end
    bus.in_valid = 4'h0;

    // 6: reset while granting with three buffers full
    reset_pulse();
    bus.in_valid  = 4'b0111;
    bus.in_data   = 8'b00_11_11_11;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 4'h0;
    step();
    check("t6_pre_ov",  32'(bus.out_valid), 32'd1);
    check("t6_pre_sel", 32'(bus.sel),       32'(2'b11));
    rst = 1'b1;
    step();
    check("t6_ready", 32'(bus.in_ready),  32'hF);
    check("t6_ov",    32'(bus.out_valid), 32'd0);
    check("t6_sel",   32'(bus.sel),       32'(2'b11));
    check("t6_d",     32'({bus.d3, bus.d2, bus.d1, bus.d0}), 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("t6_post_ov", 32'(bus.out_valid), 32'd0);
    check("t6_post_d",  32'({bus.d3, bus.d2, bus.d1, bus.d0}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
